// File: rtl/axi_lite_ptgen_pkg.sv
// axi_lite_ptgen_pkg: shared state type, AXI response codes and data-pattern helpers
// for the AXI-Lite pattern generator master.
// Build option: define PTGEN_LFSR_EN to use a 32-bit Galois LFSR pattern instead of
// the default incrementing pattern (SEED, SEED+1, ...).
package axi_lite_ptgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } ptgenState_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef PTGEN_LFSR_EN
  // Polynomial x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsrStep(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ LFSR_TAPS;
    return nxt;
  endfunction
`endif

  // Pattern word that follows cur; callers truncate to their data width
  function automatic logic [63:0] nextPattern(input logic [63:0] cur);
`ifdef PTGEN_LFSR_EN
    // The seed is 32 bits wide, so the upper half stays zero in this mode
    return {cur[63:32], lfsrStep(cur[31:0])};
`else
    return cur + 64'd1;
`endif
  endfunction

endpackage

// File: rtl/axi_lite_ptgen_pattern.sv
// axi_lite_ptgen_pattern: holds the current data pattern word P(i).
// restart_i reloads SEED (run start and start of the read-back phase),
// advance_i steps to P(i+1). Pattern kind follows PTGEN_LFSR_EN in the package.
module axi_lite_ptgen_pattern #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_0001
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              restart_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] pattern_o
);
  import axi_lite_ptgen_pkg::*;

  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

  logic [DATA_W-1:0] pat_q, pat_d;

  // Choose between reload, step and hold; reload wins if both are requested
  always_comb begin
    pat_d = pat_q;
    if (restart_i) begin
      pat_d = SEED_W;
    end else if (advance_i) begin
      pat_d = DATA_W'(nextPattern(64'(pat_q)));
    end
  end

  // Pattern register, parked at the seed while in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q <= SEED_W;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign pattern_o = pat_q;

endmodule

// File: rtl/axi_lite_ptgen_master.sv
// axi_lite_ptgen_master: AXI-Lite master that writes NUM_TXN pattern words starting at
// BASE_ADDR, reads them back, and reports failed beats through ERROR / ERR_COUNT.
// One write and one read outstanding at most. Pattern selection: PTGEN_LFSR_EN.
module axi_lite_ptgen_master #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_TXN   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       SEED      = 32'hA5A5_0001
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                INIT_AXI_TXN,
  output logic                TXN_DONE,
  output logic                ERROR,
  output logic [7:0]          ERR_COUNT,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  import axi_lite_ptgen_pkg::*;

  localparam int IDX_W      = 9;
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

  ptgenState_e       state_q, state_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              wrPend_q, wrPend_d;
  logic              rdPend_q, rdPend_d;
  logic              awValid_q, awValid_d;
  logic              wValid_q, wValid_d;
  logic              arValid_q, arValid_d;
  logic [ADDR_W-1:0] awAddr_q, awAddr_d;
  logic [ADDR_W-1:0] arAddr_q, arAddr_d;
  logic [DATA_W-1:0] wData_q, wData_d;
  logic              txnDone_q, txnDone_d;
  logic              error_q, error_d;
  logic [7:0]        errCount_q, errCount_d;
  logic              initPrev_q;

  logic              initRise;
  logic              startRun;
  logic              beatFail;
  logic              lastBeat;
  logic              patRestart;
  logic              patAdvance;
  logic [DATA_W-1:0] patWord;
  logic [ADDR_W-1:0] beatAddr;

  assign initRise = INIT_AXI_TXN && !initPrev_q;
  assign lastBeat = (beat_q == IDX_W'(NUM_TXN - 1));
  assign beatAddr = BASE_ADDR + (ADDR_W'(beat_q) << BYTE_SHIFT);

  axi_lite_ptgen_pattern #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .restart_i (patRestart),
    .advance_i (patAdvance),
    .pattern_o (patWord)
  );

  // Next-state logic: issue one beat at a time, retire it on B/R, track failures
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wrPend_d   = wrPend_q;
    rdPend_d   = rdPend_q;
    awValid_d  = awValid_q;
    wValid_d   = wValid_q;
    arValid_d  = arValid_q;
    awAddr_d   = awAddr_q;
    arAddr_d   = arAddr_q;
    wData_d    = wData_q;
    txnDone_d  = txnDone_q;
    error_d    = error_q;
    errCount_d = errCount_q;
    startRun   = 1'b0;
    beatFail   = 1'b0;
    patRestart = 1'b0;
    patAdvance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (initRise) startRun = 1'b1;
      end

      ST_WRITE: begin
        if (awValid_q && M_AXI_AWREADY) awValid_d = 1'b0;
        if (wValid_q && M_AXI_WREADY)   wValid_d  = 1'b0;
        if (!wrPend_q) begin
          awValid_d = 1'b1;
          wValid_d  = 1'b1;
          awAddr_d  = beatAddr;
          wData_d   = patWord;
          wrPend_d  = 1'b1;
        end else if (M_AXI_BVALID) begin
          wrPend_d = 1'b0;
          beatFail = (M_AXI_BRESP != RESP_OKAY);
          if (lastBeat) begin
            beat_d     = '0;
            state_d    = ST_READ;
            patRestart = 1'b1;
          end else begin
            beat_d     = beat_q + 1'b1;
            patAdvance = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (arValid_q && M_AXI_ARREADY) arValid_d = 1'b0;
        if (!rdPend_q) begin
          arValid_d = 1'b1;
          arAddr_d  = beatAddr;
          rdPend_d  = 1'b1;
        end else if (M_AXI_RVALID) begin
          rdPend_d = 1'b0;
          beatFail = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != patWord);
          if (lastBeat) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d     = beat_q + 1'b1;
            patAdvance = 1'b1;
          end
        end
      end

      ST_DONE: begin
        txnDone_d = 1'b1;
        if (initRise) startRun = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    if (beatFail) begin
      error_d = 1'b1;
      if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
    end

    if (startRun) begin
      state_d    = ST_WRITE;
      beat_d     = '0;
      wrPend_d   = 1'b0;
      rdPend_d   = 1'b0;
      txnDone_d  = 1'b0;
      error_d    = 1'b0;
      errCount_d = '0;
      patRestart = 1'b1;
    end
  end

  // State and datapath registers; reset abandons any run in flight
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      wrPend_q   <= 1'b0;
      rdPend_q   <= 1'b0;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      arValid_q  <= 1'b0;
      awAddr_q   <= '0;
      arAddr_q   <= '0;
      wData_q    <= '0;
      txnDone_q  <= 1'b0;
      error_q    <= 1'b0;
      errCount_q <= '0;
      initPrev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wrPend_q   <= wrPend_d;
      rdPend_q   <= rdPend_d;
      awValid_q  <= awValid_d;
      wValid_q   <= wValid_d;
      arValid_q  <= arValid_d;
      awAddr_q   <= awAddr_d;
      arAddr_q   <= arAddr_d;
      wData_q    <= wData_d;
      txnDone_q  <= txnDone_d;
      error_q    <= error_d;
      errCount_q <= errCount_d;
      initPrev_q <= INIT_AXI_TXN;
    end
  end

  assign M_AXI_AWADDR  = awAddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awValid_q;
  assign M_AXI_WDATA   = wData_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wValid_q;
  assign M_AXI_BREADY  = (state_q == ST_WRITE);
  assign M_AXI_ARADDR  = arAddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arValid_q;
  assign M_AXI_RREADY  = (state_q == ST_READ);
  assign TXN_DONE      = txnDone_q;
  assign ERROR         = error_q;
  assign ERR_COUNT     = errCount_q;

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// tb_axi_lite_ptgen_master: drives the pattern generator against a small AXI-Lite
// slave model; expected beats and run results are queued per run and compared by
// a monitor whenever the DUT handshakes or raises TXN_DONE.
module tb_axi_lite_ptgen_master;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          NUM_TXN = 4;
  localparam logic [31:0] SEED    = 32'hA5A5_0001;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic                INIT_AXI_TXN;
  logic                TXN_DONE;
  logic                ERROR;
  logic [7:0]          ERR_COUNT;
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  axi_lite_ptgen_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_TXN   (NUM_TXN),
    .BASE_ADDR (32'h0),
    .SEED      (SEED)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .INIT_AXI_TXN  (INIT_AXI_TXN),
    .TXN_DONE      (TXN_DONE),
    .ERROR         (ERROR),
    .ERR_COUNT     (ERR_COUNT),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  // 10 time-unit clock period
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  logic [31:0] awQ[$];
  logic [31:0] wQ[$];
  logic [31:0] arQ[$];
  logic [8:0]  resQ[$];

  logic [1:0]  cfgBresp = 2'b00;
  int          cfgCorrupt = -1;
  int          cfgWDelay = 0;
  logic [31:0] mem [0:255];

  task automatic reportFail(input string name, input logic [63:0] act, input logic [63:0] exp);
    errors++;
    $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) reportFail(name, act, exp);
  endtask

  // Hand-computed beat addresses for BASE_ADDR 0 and 4-byte beats
  function automatic logic [31:0] expAddr(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0004;
      2:       return 32'h0000_0008;
      default: return 32'h0000_000C;
    endcase
  endfunction

  function automatic logic [31:0] expPattern(input int i);
`ifdef PTGEN_LFSR_EN
    logic [31:0] v;
    v = SEED;
    for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
`else
    case (i)
      0:       return 32'hA5A5_0001;
      1:       return 32'hA5A5_0002;
      2:       return 32'hA5A5_0003;
      default: return 32'hA5A5_0004;
    endcase
`endif
  endfunction

  task automatic flushQueues();
    awQ.delete();
    wQ.delete();
    arQ.delete();
    resQ.delete();
  endtask

  task automatic pushRun(input int expErr);
    for (int i = 0; i < NUM_TXN; i++) begin
      awQ.push_back(expAddr(i));
      wQ.push_back(expPattern(i));
      arQ.push_back(expAddr(i));
    end
    resQ.push_back({expErr != 0, 8'(expErr)});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_awvalid"}, M_AXI_AWVALID, 0);
    checkOutput({tag, "_wvalid"},  M_AXI_WVALID, 0);
    checkOutput({tag, "_bready"},  M_AXI_BREADY, 0);
    checkOutput({tag, "_arvalid"}, M_AXI_ARVALID, 0);
    checkOutput({tag, "_rready"},  M_AXI_RREADY, 0);
    checkOutput({tag, "_awaddr"},  M_AXI_AWADDR, 0);
    checkOutput({tag, "_wdata"},   M_AXI_WDATA, 0);
    checkOutput({tag, "_araddr"},  M_AXI_ARADDR, 0);
    checkOutput({tag, "_done"},    TXN_DONE, 0);
    checkOutput({tag, "_error"},   ERROR, 0);
    checkOutput({tag, "_errcnt"},  ERR_COUNT, 0);
  endtask

  task automatic waitDone(input int startCount);
    int cyc;
    cyc = 0;
    while (doneCount == startCount && cyc < 2000) begin
      @(negedge ACLK);
      cyc++;
    end
    if (doneCount == startCount) begin
      checks++;
      reportFail("done_timeout", 0, 1);
      flushQueues();
    end
  endtask

  // Configure the slave, queue the expected run, pulse INIT and wait for completion
  task automatic applyStimulus(input logic [1:0] bresp, input int corrupt, input int wDelay,
                               input int holdCycles, input int expErr);
    int startCount;
    cfgBresp   = bresp;
    cfgCorrupt = corrupt;
    cfgWDelay  = wDelay;
    pushRun(expErr);
    startCount = doneCount;
    INIT_AXI_TXN = 1'b1;
    repeat (holdCycles) @(negedge ACLK);
    INIT_AXI_TXN = 1'b0;
    waitDone(startCount);
    repeat (3) @(negedge ACLK);
  endtask

  // Slave model: samples handshakes at the falling edge, updates its outputs just after the rising edge
  initial begin
    logic        sAwHs, sWHs, sBHs, sArHs, sRHs;
    logic [31:0] sAwAddr, sWData, sArAddr, awA, wD;
    logic        gotAw, gotW;
    int          wCnt;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_ARREADY = 1'b1;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    gotAw = 1'b0;
    gotW  = 1'b0;
    awA   = '0;
    wD    = '0;
    wCnt  = 0;
    forever begin
      @(negedge ACLK);
      sAwHs   = M_AXI_AWVALID && M_AXI_AWREADY;
      sWHs    = M_AXI_WVALID && M_AXI_WREADY;
      sBHs    = M_AXI_BVALID && M_AXI_BREADY;
      sArHs   = M_AXI_ARVALID && M_AXI_ARREADY;
      sRHs    = M_AXI_RVALID && M_AXI_RREADY;
      sAwAddr = M_AXI_AWADDR;
      sWData  = M_AXI_WDATA;
      sArAddr = M_AXI_ARADDR;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        gotAw = 1'b0;
        gotW  = 1'b0;
        wCnt  = 0;
        M_AXI_BVALID = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_WREADY = (cfgWDelay == 0);
      end else begin
        if (sAwHs) begin
          gotAw = 1'b1;
          awA   = sAwAddr;
          wCnt  = 0;
        end
        if (sWHs) begin
          gotW = 1'b1;
          wD   = sWData;
        end
        if (sBHs) M_AXI_BVALID = 1'b0;
        if (gotAw && gotW) begin
          mem[awA[9:2]] = wD;
          M_AXI_BVALID  = 1'b1;
          M_AXI_BRESP   = cfgBresp;
          gotAw = 1'b0;
          gotW  = 1'b0;
        end
        if (cfgWDelay == 0) begin
          M_AXI_WREADY = 1'b1;
        end else begin
          if (gotAw && !gotW) wCnt++;
          M_AXI_WREADY = gotAw && !gotW && (wCnt >= cfgWDelay);
        end
        if (sRHs) M_AXI_RVALID = 1'b0;
        if (sArHs) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RRESP  = 2'b00;
          M_AXI_RDATA  = mem[sArAddr[9:2]];
          if (int'(sArAddr[9:2]) == cfgCorrupt) M_AXI_RDATA = M_AXI_RDATA ^ 32'h0000_0100;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and on each TXN_DONE rise
  initial begin
    logic        pAwV, pWV, pArV, pAwHs, pWHs, pArHs, pDone;
    logic [31:0] pAwAddr, pWData, pArAddr;
    logic [8:0]  res;
    pAwV = 0; pWV = 0; pArV = 0; pAwHs = 0; pWHs = 0; pArHs = 0; pDone = 0;
    pAwAddr = '0; pWData = '0; pArAddr = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        pAwV = 0; pWV = 0; pArV = 0; pAwHs = 0; pWHs = 0; pArHs = 0; pDone = 0;
      end else begin
        if (pAwV && !pAwHs) checkOutput("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, pAwAddr});
        if (pWV && !pWHs)   checkOutput("w_hold",  {M_AXI_WVALID, M_AXI_WDATA},   {1'b1, pWData});
        if (pArV && !pArHs) checkOutput("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, pArAddr});
        if (M_AXI_AWVALID && !pAwV) checkOutput("aw_w_together", {M_AXI_WVALID, pWV}, 2'b10);
        if (M_AXI_BVALID) checkOutput("bready", M_AXI_BREADY, 1);
        if (M_AXI_RVALID) checkOutput("rready", M_AXI_RREADY, 1);
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          if (awQ.size() == 0) begin
            checks++;
            reportFail("aw_extra", M_AXI_AWADDR, 0);
          end else begin
            checkOutput("aw_addr", M_AXI_AWADDR, awQ.pop_front());
          end
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          if (wQ.size() == 0) begin
            checks++;
            reportFail("w_extra", M_AXI_WDATA, 0);
          end else begin
            checkOutput("w_data", {M_AXI_WSTRB, M_AXI_WDATA}, {4'hF, wQ.pop_front()});
          end
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (arQ.size() == 0) begin
            checks++;
            reportFail("ar_extra", M_AXI_ARADDR, 0);
          end else begin
            checkOutput("ar_addr", M_AXI_ARADDR, arQ.pop_front());
          end
        end
        if (TXN_DONE && !pDone) begin
          doneCount++;
          checkOutput("beats_left", awQ.size() + wQ.size() + arQ.size(), 0);
          if (resQ.size() == 0) begin
            checks++;
            reportFail("done_extra", 1, 0);
          end else begin
            res = resQ.pop_front();
            checkOutput("error_flag", ERROR, res[8]);
            checkOutput("err_count", ERR_COUNT, res[7:0]);
          end
        end
        pAwV    = M_AXI_AWVALID;
        pWV     = M_AXI_WVALID;
        pArV    = M_AXI_ARVALID;
        pAwHs   = M_AXI_AWVALID && M_AXI_AWREADY;
        pWHs    = M_AXI_WVALID && M_AXI_WREADY;
        pArHs   = M_AXI_ARVALID && M_AXI_ARREADY;
        pAwAddr = M_AXI_AWADDR;
        pWData  = M_AXI_WDATA;
        pArAddr = M_AXI_ARADDR;
        pDone   = TXN_DONE;
      end
    end
  end

  // Directed sequence of runs
  initial begin
    int cyc;
    ARESETN      = 1'b0;
    INIT_AXI_TXN = 1'b0;
    repeat (2) @(negedge ACLK);
    checkResetState("por");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (16) @(negedge ACLK);

    $display("[TB] clean run, init at t=200");
    applyStimulus(2'b00, -1, 0, 2, 0);

    $display("[TB] read data of beat 2 corrupted");
    applyStimulus(2'b00, 2, 0, 2, 1);

    $display("[TB] SLVERR on every write response");
    applyStimulus(2'b10, -1, 0, 2, 4);

    $display("[TB] WREADY delayed after AW handshake");
    applyStimulus(2'b00, -1, 3, 2, 0);

    $display("[TB] reset during write beat 1");
    cfgBresp = 2'b00; cfgCorrupt = -1; cfgWDelay = 0;
    pushRun(0);
    INIT_AXI_TXN = 1'b1;
    repeat (2) @(negedge ACLK);
    INIT_AXI_TXN = 1'b0;
    cyc = 0;
    while (!(M_AXI_AWVALID && M_AXI_AWADDR == 32'h4) && cyc < 200) begin
      @(negedge ACLK);
      cyc++;
    end
    checkOutput("beat1_reached", M_AXI_AWVALID && M_AXI_AWADDR == 32'h4, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    flushQueues();
    checkResetState("midrun");
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    checkOutput("no_resume", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, TXN_DONE}, 0);
    applyStimulus(2'b00, -1, 0, 2, 0);

    $display("[TB] INIT held high for 50 cycles");
    applyStimulus(2'b10, -1, 0, 50, 4);
    repeat (10) @(negedge ACLK);
    checkOutput("held_done", TXN_DONE, 1);
    checkOutput("held_error", ERROR, 1);
    checkOutput("held_idle", {M_AXI_AWVALID, M_AXI_ARVALID}, 0);

    $display("[TB] second pulse after DONE");
    applyStimulus(2'b00, -1, 0, 2, 0);

    checkOutput("queues_empty", awQ.size() + wQ.size() + arQ.size() + resQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_ptgen_master.md
AXI_LITE_PTGEN_MASTER -- requirements
Module: axi_lite_ptgen_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32 (32 or 64 only), AXI-Lite data width.
REQ-003 SHALL have parameter NUM_TXN, default 4 (1..256), number of write/read beats per run.
REQ-004 SHALL have parameter BASE_ADDR, default 0, start address of the target window.
REQ-005 SHALL have parameter SEED, default 32'hA5A5_0001, first data pattern word.
REQ-006 SHALL have port ACLK, in, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port ARESETN, in, 1, asynchronous active-low reset.
REQ-008 SHALL have port INIT_AXI_TXN, in, 1, run request; its rising edge starts a run.
REQ-009 SHALL have port TXN_DONE, out, 1, run complete.
REQ-010 SHALL have port ERROR, out, 1, sticky failure flag for the current run.
REQ-011 SHALL have port ERR_COUNT, out, 8, count of failed beats (saturating at 255).
REQ-012 SHALL have AW channel ports: M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3 (tied 3'b000), M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-013 SHALL have W channel ports: M_AXI_WDATA out DATA_W, M_AXI_WSTRB out DATA_W/8 (all ones), M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-014 SHALL have B channel ports: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-015 SHALL have AR/R channel ports: M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3 (0), M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID, M_AXI_RREADY.

Function
REQ-016 SHALL implement FSM IDLE -> WRITE -> READ -> DONE; DONE -> WRITE on the next INIT_AXI_TXN rising edge.
REQ-017 SHALL detect the INIT rising edge with a one-flop history; a level held high starts only one run; edges outside IDLE/DONE are ignored.
REQ-018 SHALL, on run start, clear ERROR, ERR_COUNT, TXN_DONE, and beat index i.
REQ-019 SHALL, in WRITE, present beat i at address BASE_ADDR + i*(DATA_W/8) with data pattern P(i).
REQ-020 SHALL assert AWVALID and WVALID together in the same cycle; each is held until its own handshake, independently; neither returns high until the B response for that beat arrives.
REQ-021 SHALL assert BREADY continuously in WRITE; BRESP != 2'b00 flags the beat as failed.
REQ-022 SHALL allow at most one outstanding write and one outstanding read.
REQ-023 SHALL, after B of beat NUM_TXN-1, reset i to 0 and enter READ.
REQ-024 SHALL, in READ, hold ARVALID until handshake; RREADY is high continuously; a beat fails if RRESP != 0 or RDATA != P(i).
REQ-025 SHALL, after R of beat NUM_TXN-1, enter DONE and assert TXN_DONE the following cycle, held until the next run starts.
REQ-026 SHALL set ERROR on the first failed beat and increment ERR_COUNT per failed beat, saturating at 255.
REQ-027 SHALL tolerate VALID/READY in any order and simultaneous AW/W handshakes in one cycle.

Reset
REQ-028 SHALL, on ARESETN low, immediately force IDLE, all VALIDs/READYs 0, addresses/data 0, TXN_DONE 0, ERROR 0, ERR_COUNT 0, edge flop 0.
REQ-029 SHALL abandon any run in progress when reset asserts mid-transaction; no resume after release.

Configuration
REQ-030 SHALL use macro PTGEN_LFSR_EN: defined -> P(0)=SEED, P(i+1)=32-bit Galois LFSR step (taps 32,22,2,1) of P(i), zero-extended for DATA_W=64; undefined -> P(i)=SEED+i modulo 2^DATA_W.

Structure
REQ-031 SHALL place the FSM state enum, AXI response constants (OKAY=2'b00) and the pattern function in package axi_lite_ptgen_pkg.
REQ-032 SHALL contain one sub-module, axi_lite_ptgen_pattern, generating P(i) and recomputing from SEED at READ start.

Verification
REQ-033 SHALL check that an always-ready OKAY slave with NUM_TXN=4, init pulse at 200 ns gives writes to 0x0,0x4,0x8,0xC with SEED..SEED+3, matching reads, TXN_DONE=1, ERROR=0.
REQ-034 SHALL check that a slave corrupting read data of beat 2 gives ERROR=1 and ERR_COUNT=1 at TXN_DONE.
REQ-035 SHALL check that a slave returning BRESP=2'b10 on all writes with NUM_TXN=4 gives ERR_COUNT=4 and ERROR=1.
REQ-036 SHALL check that WREADY delayed 3 cycles after AWREADY gives each VALID held until its handshake, with no duplicate beats.
REQ-037 SHALL check that ARESETN low during beat 1 of WRITE, then INIT reissued, gives a clean full run from address 0x0.
REQ-038 SHALL check that INIT held high for 50 cycles gives exactly one run; a second pulse after DONE gives a second run that clears ERROR.
